// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared constants and types for the round-robin hold arbiter
package rr_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational circular priority search starting at pointer
module rr_pick
  import rr_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           pointer,
  output logic               found,
  output req_idx_t           idx
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  // Index arithmetic wraps in IDX_W bits, which equals mod NUM_REQ.
  always_comb begin
    found = 1'b0;
    idx   = pointer;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[pointer + req_idx_t'(k)]) begin
        found = 1'b1;
        idx   = pointer + req_idx_t'(k);
      end
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - round-robin arbiter with bounded grant hold time
module rr_hold_arbiter
  import rr_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               arb_clk,
  input  logic               arb_rst,
  input  logic               arb_en,
  input  logic [NUM_REQ-1:0] arb_req,
  output logic [NUM_REQ-1:0] arb_gnt,
  output req_idx_t           arb_gnt_id,
  output req_idx_t           pointer,
  output logic               arb_timeout
);

  localparam int                        HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]         HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [NUM_REQ-1:0]        GNT_ONE  = NUM_REQ'(1);

  arb_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              pick_found;
  req_idx_t          pick_idx;

  rr_pick u_pick (
    .req     (arb_req),
    .pointer (pointer),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // Grant FSM: IDLE picks a new owner, GRANT holds it until release or hold limit.
  always_ff @(posedge arb_clk) begin
    if (arb_rst) begin
      state       <= IDLE;
      arb_gnt     <= '0;
      arb_gnt_id  <= '0;
      pointer     <= '0;
      arb_timeout <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      arb_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en && pick_found) begin
            state      <= GRANT;
            arb_gnt    <= GNT_ONE << pick_idx;
            arb_gnt_id <= pick_idx;
            hold_cnt   <= HOLD_W'(1);
          end
        end
        GRANT: begin
          // Arb_en is deliberately ignored here: disabling only blocks new grants.
          if (!arb_req[arb_gnt_id] || hold_cnt == HOLD_MAX) begin
            state       <= IDLE;
            arb_gnt     <= '0;
            hold_cnt    <= '0;
            pointer     <= arb_gnt_id + req_idx_t'(1);
            arb_timeout <= arb_req[arb_gnt_id];
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          arb_gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb/tb_rr_hold_arbiter.sv - scoreboard bench for rr_hold_arbiter at MAX_HOLD=8
module tb_rr_hold_arbiter;

  localparam int MAX_HOLD = 8;

  logic       arb_clk;
  logic       arb_rst;
  logic       arb_en;
  logic [3:0] arb_req;
  logic [3:0] arb_gnt;
  logic [1:0] arb_gnt_id;
  logic [1:0] pointer;
  logic       arb_timeout;

  rr_hold_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .arb_clk     (arb_clk),
    .arb_rst     (arb_rst),
    .arb_en      (arb_en),
    .arb_req     (arb_req),
    .arb_gnt     (arb_gnt),
    .arb_gnt_id  (arb_gnt_id),
    .pointer     (pointer),
    .arb_timeout (arb_timeout)
  );

  initial arb_clk = 1'b0;
  always #5 arb_clk = ~arb_clk;

  // Grant is one-hot or zero, and the id names the granted bit.
  a_onehot: assert property (@(posedge arb_clk) $onehot0(arb_gnt));
  a_id: assert property (@(posedge arb_clk) (arb_gnt != 4'b0) |-> arb_gnt[arb_gnt_id]);
  // A grant bit can only be set if that request was sampled at the previous edge.
  for (genvar g = 0; g < 4; g++) begin : g_req
    a_req: assert property (@(posedge arb_clk) arb_gnt[g] |-> $past(arb_req[g]));
  end

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       id_known;
    logic [1:0] ptr;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_valid = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Predict the state after the coming edge from the inputs about to be sampled.
  task automatic model_push();
    exp_t e;
    bit   tmo = 1'b0;
    bit   known = 1'b0;
    if (arb_rst) begin
      m_valid = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; known = 1'b1;
    end else if (!m_valid) begin
      if (arb_en) begin
        for (int k = 0; k < 4; k++) begin
          int c = (m_ptr + k) % 4;
          if (arb_req[c] && !m_valid) begin
            m_valid = 1'b1; m_owner = c; m_cnt = 1;
          end
        end
      end
    end else if (!arb_req[m_owner]) begin
      m_valid = 1'b0; m_ptr = (m_owner + 1) % 4;
    end else if (m_cnt == MAX_HOLD) begin
      m_valid = 1'b0; m_ptr = (m_owner + 1) % 4; tmo = 1'b1;
    end else begin
      m_cnt++;
    end
    e.gnt      = m_valid ? (4'b0001 << m_owner) : 4'b0000;
    e.id       = 2'(m_owner);
    e.id_known = known | m_valid;
    e.ptr      = 2'(m_ptr);
    e.tmo      = tmo;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_push();
    @(posedge arb_clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("gnt", 32'(arb_gnt), 32'(e.gnt));
      check("ptr", 32'(pointer), 32'(e.ptr));
      check("tmo", 32'(arb_timeout), 32'(e.tmo));
      if (e.id_known) check("gnt_id", 32'(arb_gnt_id), 32'(e.id));
    end
  endtask

  task automatic do_reset();
    arb_rst = 1'b1;
    cycle();
    cycle();
    arb_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         gcount;
    int         tcount;
    int         gc;
    int         b2b;
    int         rr[4];
    logic [3:0] req_v;
    logic [3:0] prev_g;
    int         order[$];
    int         ptr_at[$];
    bit         seen_to;

    arb_rst = 1'b1; arb_en = 1'b0; arb_req = 4'b0000;
    do_reset();
    check("rst_gnt", 32'(arb_gnt), 0);
    check("rst_ptr", 32'(pointer), 0);
    check("rst_gid", 32'(arb_gnt_id), 0);

    // Continuous request from 2: 8 grant cycles, timeout, pointer 3, re-grant
    arb_en = 1'b1; arb_req = 4'b0100;
    gcount = 0; seen_to = 1'b0;
    for (int n = 0; n < 20 && !seen_to; n++) begin
      cycle();
      if (arb_timeout) begin
        seen_to = 1'b1;
        check("to_gnt_zero", 32'(arb_gnt), 0);
        check("to_ptr", 32'(pointer), 3);
        cycle();
        check("regrant", 32'(arb_gnt), 32'(4'b0100));
      end else if (arb_gnt == 4'b0100) begin
        gcount++;
      end
    end
    check("hold_cycles", 32'(gcount), MAX_HOLD);
    check("timeout_seen", 32'(seen_to), 1);

    // All requesting, each owner drops after 3 grant cycles, re-raises 2 later
    do_reset();
    req_v = 4'b1111; arb_req = req_v; prev_g = 4'b0;
    gc = 0; tcount = 0; b2b = 0;
    for (int i = 0; i < 4; i++) rr[i] = 0;
    for (int n = 0; n < 24; n++) begin
      cycle();
      for (int i = 0; i < 4; i++) begin
        if (rr[i] > 0) begin
          rr[i]--;
          if (rr[i] == 0) req_v[i] = 1'b1;
        end
      end
      if (arb_gnt != 4'b0) begin
        if (prev_g == 4'b0) order.push_back(int'(arb_gnt_id));
        else if (prev_g != arb_gnt) b2b++;
        gc++;
        if (gc == 3) begin
          req_v[arb_gnt_id] = 1'b0;
          rr[arb_gnt_id] = 2;
        end
      end else begin
        gc = 0;
      end
      if (arb_timeout) tcount++;
      prev_g = arb_gnt;
      arb_req = req_v;
    end
    check("rr_grants", 32'(order.size() >= 5), 1);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check("rr_order", 32'(order[i]), 32'(i % 4));
    check("rr_no_timeout", 32'(tcount), 0);
    check("rr_gap", 32'(b2b), 0);

    // Pointer 2 after releasing 1, then 4'b1001 goes to 3 first, then 0
    do_reset();
    arb_req = 4'b0010;
    cycle();
    arb_req = 4'b0000;
    cycle();
    check("ptr_after_1", 32'(pointer), 2);
    arb_req = 4'b1001; prev_g = 4'b0;
    order.delete();
    for (int n = 0; n < 25; n++) begin
      cycle();
      if (arb_gnt != 4'b0 && prev_g == 4'b0) begin
        order.push_back(int'(arb_gnt_id));
        ptr_at.push_back(int'(pointer));
      end
      prev_g = arb_gnt;
    end
    check("wrap_cnt", 32'(order.size() >= 2), 1);
    if (order.size() >= 2) begin
      check("wrap_first", 32'(order[0]), 3);
      check("wrap_second", 32'(order[1]), 0);
      check("wrap_ptr", 32'(ptr_at[1]), 0);
    end

    // Owner drops in its first grant cycle
    do_reset();
    arb_req = 4'b0001;
    cycle();
    check("short_gnt", 32'(arb_gnt), 1);
    arb_req = 4'b0000;
    cycle();
    check("short_rel", 32'(arb_gnt), 0);
    check("short_tmo", 32'(arb_timeout), 0);

    // Reset in the 4th grant cycle
    do_reset();
    arb_req = 4'b0100;
    for (int n = 0; n < 4; n++) cycle();
    check("mid_gnt", 32'(arb_gnt), 32'(4'b0100));
    arb_rst = 1'b1;
    cycle();
    check("mid_rst_gnt", 32'(arb_gnt), 0);
    check("mid_rst_ptr", 32'(pointer), 0);
    check("mid_rst_tmo", 32'(arb_timeout), 0);
    arb_rst = 1'b0; arb_req = 4'b0010;
    cycle();
    check("post_rst_gnt", 32'(arb_gnt), 32'(4'b0010));

    // Enable gating: no grant while disabled, disabling later does not revoke
    do_reset();
    arb_en = 1'b0; arb_req = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("en_off", 32'(arb_gnt), 0);
    end
    arb_en = 1'b1;
    cycle();
    check("en_on", 32'(arb_gnt), 1);
    arb_en = 1'b0; arb_req = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      cycle();
      check("en_hold", 32'(arb_gnt), 1);
    end
    arb_en = 1'b1; arb_req = 4'b0000;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      arb_rst = ($urandom_range(0, 59) == 0);
      arb_en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) arb_req = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

Interface
Parameters:
- REQ-001 NUM_REQ, 4, number of requesters; the design SHALL be verified at 4.
- REQ-002 MAX_HOLD, 8, maximum consecutive cycles one owner SHALL hold a grant; legal range 1..255.

Ports:
- REQ-003 arb_clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-004 arb_rst  input  1  reset; synchronous, active-high.
- REQ-005 arb_en  input  1  arbitration enable; gates new grants only.
- REQ-006 arb_req  input  NUM_REQ  request vector; bit i high means requester i wants or keeps the resource.
- REQ-007 arb_gnt  output  NUM_REQ  registered one-hot grant, or all-zero.
- REQ-008 arb_gnt_id  output  2  index of current owner; valid only while arb_gnt is non-zero.
- REQ-009 pointer  output  2  highest-priority requester for the next arbitration.
- REQ-010 arb_timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
- REQ-011 FSM states SHALL be IDLE (no owner) and GRANT (one owner).
- REQ-012 In IDLE, at an edge with arb_en=1 and arb_req non-zero, the block SHALL select the first set bit found by circular search starting at pointer (pointer, pointer+1, ... mod 4).
- REQ-013 After that selection, on the same edge, arb_gnt/arb_gnt_id SHALL assert and hold_cnt SHALL load 1, giving a latency of 1 cycle from sampled request to visible grant.
- REQ-014 In IDLE with arb_en=0 or arb_req=0, arb_gnt SHALL remain 0.
- REQ-015 In GRANT, at each edge, if arb_req[arb_gnt_id]=0 the grant SHALL release: arb_gnt=0 the next cycle, no timeout pulse.
- REQ-016 In GRANT, else if hold_cnt==MAX_HOLD the grant SHALL release with arb_timeout=1 for exactly the next cycle.
- REQ-017 In GRANT, otherwise hold_cnt SHALL increment and the grant SHALL hold; a continuously requesting owner therefore holds exactly MAX_HOLD cycles.
- REQ-018 On release, pointer SHALL become (arb_gnt_id+1) mod 4 (wrap 3->0) and the state SHALL return to IDLE.
- REQ-019 Every release SHALL produce exactly one all-zero grant cycle before any new grant.
- REQ-020 arb_en=0 during GRANT SHALL NOT revoke the current grant.
- REQ-021 Requests from non-owners arriving during GRANT SHALL be ignored until IDLE; no state SHALL be stored for them.
- REQ-022 pointer SHALL change only on release.
- REQ-023 hold_cnt SHALL be $clog2(MAX_HOLD+1) bits wide and SHALL never exceed MAX_HOLD.
- REQ-024 arb_gnt SHALL always be $onehot0, and arb_gnt_id SHALL match it whenever it is non-zero.

Reset
- REQ-025 While arb_rst=1 at an edge, the next cycle SHALL show state=IDLE, arb_gnt=0, arb_gnt_id=0, pointer=0, arb_timeout=0 and hold_cnt=0.
- REQ-026 Reset asserted mid-grant SHALL drop the grant with no timeout pulse and no pointer advance.
- REQ-027 The first grant after reset deassertion SHALL appear no earlier than 1 cycle after the first edge sampled with arb_rst=0.

Structure
- REQ-028 Package rr_pkg SHALL hold NUM_REQ, the state enum type (IDLE, GRANT) and the requester-index typedef.
- REQ-029 The circular priority search SHALL be a combinational sub-module, rr_pick: inputs req and pointer; outputs found and idx.
- REQ-030 All outputs SHALL be driven directly from flops.

Verification (MAX_HOLD=8)
- REQ-031 Reset, then arb_req=4'b0100 held with arb_en=1:
  - arb_gnt=4'b0100 for 8 cycles;
  - then a cycle with arb_gnt=0 and arb_timeout=1, pointer=3;
  - then re-grant of 4'b0100.
- REQ-032 From pointer=0, arb_req=4'b1111, each owner drops its bit after 3 grant cycles and re-raises it 2 cycles later:
  - grant order 0,1,2,3,0;
  - one zero cycle between grants;
  - no timeout.
- REQ-033 pointer=2 after releasing requester 1, with arb_req=4'b1001: grant goes to requester 3 first, pointer becomes 0, then requester 0.
- REQ-034 Owner deasserts its request in its first grant cycle: grant is visible exactly 1 cycle, arb_timeout=0.
- REQ-035 arb_rst=1 in the 4th cycle of a grant:
  - next cycle arb_gnt=0, pointer=0, arb_timeout=0;
  - after deassertion, arb_req=4'b0010 is granted 1 cycle later.
- REQ-036 arb_en=0 with arb_req=4'b0001 for 5 cycles gives no grant; setting arb_en=1 gives arb_gnt=4'b0001 one cycle later.
- REQ-037 All scenarios SHALL run concurrent assertions for REQ-024 and for arb_gnt[i] implies arb_req[i] sampled at the previous edge.
